i2s_receiver: RTL and testbench

// - Upstream stage of the cascaded three-band EQ.
// - Deserialises a standard Philips I2S stream from the ADC into signed 16-bit left and right samples.
// - Runs entirely in the fast clk domain: bclk, lrclk and sdin are oversampled, not used as clocks.
// - Outputs feed the EQ sample input. lrclk_sync is exported for the EQ edge trigger.

---
 rtl/i2s_receiver_if.sv | 27 ++
 rtl/i2s_receiver.sv | 140 ++++++++++++++
 tb/tb_i2s_receiver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_receiver_if.sv
// Sample-side bus of the I2S receiver feeding the EQ sample input.
// master = receiver, slave = EQ.
interface i2s_receiver_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] left_sample;
    logic signed [DATA_W-1:0] right_sample;
    logic                     sample_valid;
    logic                     frame_err;
    logic                     lrclk_sync;

    modport master (
        output left_sample,
        output right_sample,
        output sample_valid,
        output frame_err,
        output lrclk_sync
    );

    modport slave (
        input left_sample,
        input right_sample,
        input sample_valid,
        input frame_err,
        input lrclk_sync
    );
endinterface

// File: rtl/i2s_receiver.sv
// Philips I2S deserialiser, oversampled in the clk domain.
// Emits signed left/right words and a pulse per complete stereo pair.
module i2s_receiver #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i2s_bclk,
    input  logic           i2s_lrclk,
    input  logic           i2s_sdin,
    i2s_receiver_if.master smp
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] FULL = CW'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] bclk_sh;
    logic [SYNC_STAGES-1:0] lrclk_sh;
    logic [SYNC_STAGES-1:0] sdin_sh;
    logic                   bclk_prev;
    logic                   ws_prev;
    logic                   chan;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_W-1:0]      shreg;
    logic [DATA_W-1:0]      left_q;
    logic [DATA_W-1:0]      right_q;
    logic                   valid_q;
    logic                   err_q;

    logic bclk_rise;
    logic ws;
    logic sd;
    logic ws_chg;
    logic start;
    logic shift;
    logic latch;
    logic err;

    assign bclk_rise = bclk_sh[SYNC_STAGES-1] & ~bclk_prev;
    assign ws        = lrclk_sh[SYNC_STAGES-1];
    assign sd        = sdin_sh[SYNC_STAGES-1];
    assign ws_chg    = ws ^ ws_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        shift    = 1'b0;
        latch    = 1'b0;
        err      = 1'b0;
        unique case (state)
            IDLE, HOLD: begin
                if (bclk_rise && ws_chg) begin
                    state_nx = SHIFT;
                    start    = 1'b1;
                end
            end
            SHIFT: begin
                // completed word is latched on the clk after its last shift
                if (bit_cnt == FULL) begin
                    latch    = 1'b1;
                    state_nx = HOLD;
                end else if (bclk_rise) begin
                    if (ws_chg) begin
                        err   = 1'b1;
                        start = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bclk_sh   <= '0;
            lrclk_sh  <= '0;
            sdin_sh   <= '0;
            bclk_prev <= 1'b0;
            ws_prev   <= 1'b0;
            chan      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bclk_sh   <= {bclk_sh[SYNC_STAGES-2:0], i2s_bclk};
            lrclk_sh  <= {lrclk_sh[SYNC_STAGES-2:0], i2s_lrclk};
            sdin_sh   <= {sdin_sh[SYNC_STAGES-2:0], i2s_sdin};
            bclk_prev <= bclk_sh[SYNC_STAGES-1];
            valid_q   <= 1'b0;
            err_q     <= err;
            if (bclk_rise) begin
                ws_prev <= ws;
            end
            if (start) begin
                bit_cnt <= '0;
                chan    <= ws;
            end
            if (shift) begin
                shreg   <= {shreg[DATA_W-2:0], sd};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (latch) begin
                if (chan) begin
                    right_q <= shreg;
                    valid_q <= 1'b1;
                end else begin
                    left_q <= shreg;
                end
            end
        end
    end

    assign smp.left_sample  = left_q;
    assign smp.right_sample = right_q;
    assign smp.sample_valid = valid_q;
    assign smp.frame_err    = err_q;
    assign smp.lrclk_sync   = lrclk_sh[SYNC_STAGES-1];
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives I2S frames with
// hand-chosen words and checks outputs with immediate assertions.
module tb_i2s_receiver;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic sdin = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int sv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    logic [15:0] last_right = '0;
    bit jitter = 1'b0;

    i2s_receiver_if #(.DATA_W(16)) bus ();

    i2s_receiver #(
        .DATA_W(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i2s_bclk(bclk),
        .i2s_lrclk(lrclk),
        .i2s_sdin(sdin),
        .smp(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sample_valid) begin
            sv_cnt++;
            last_right = bus.right_sample;
        end
        if (bus.frame_err) fe_cnt++;
        if (bus.sample_valid && bus.frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bclk_period(input logic lr, input logic sd);
        int r;
        int l;
        r = jitter ? int'($urandom_range(11, 8)) : 8;
        l = r / 2;
        bclk = 1'b0;
        lrclk = lr;
        sdin = sd;
        wait_clks(l);
        bclk = 1'b1;
        wait_clks(r - l);
    endtask

    // position 0 is the I2S delay bit; the word follows MSB first
    task automatic send_slot(input logic lr, input logic [31:0] w,
                             input int p_from, input int p_to);
        for (int p = p_from; p < p_to; p++) begin
            if (p >= 1 && p <= 32) bclk_period(lr, w[32-p]);
            else bclk_period(lr, 1'b0);
        end
    endtask

    task automatic slot(input logic lr, input logic [15:0] w, input int n);
        send_slot(lr, {w, 16'h0000}, 0, n);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bclk = 1'b0;
        lrclk = 1'b0;
        sdin = 1'b0;
        wait_clks(6);
        reset = 1'b1;
        wait_clks(2);
    endtask

    initial begin
        int s_sv;
        int s_fe;
        logic [15:0] lw;
        logic [15:0] rw;

        wait_clks(1);
        do_reset();
        check("rst_left", bus.left_sample, 16'h0000);
        check("rst_right", bus.right_sample, 16'h0000);
        check("rst_valid", 16'(bus.sample_valid), 16'h0000);
        check("rst_ferr", 16'(bus.frame_err), 16'h0000);
        check("rst_lrsync", 16'(bus.lrclk_sync), 16'h0000);

        // lrclk never toggles: nothing may be captured
        for (int i = 0; i < 20; i++) bclk_period(1'b0, 1'b1);
        check("idle_valid_cnt", 16'(sv_cnt), 16'd0);
        check("idle_ferr_cnt", 16'(fe_cnt), 16'd0);
        check("idle_left", bus.left_sample, 16'h0000);
        check("idle_right", bus.right_sample, 16'h0000);

        // 16-bclk slots: LSB collides with the ws edge -> short slot
        do_reset();
        s_sv = sv_cnt;
        s_fe = fe_cnt;
        slot(1'b1, 16'h1111, 16);
        slot(1'b0, 16'h2222, 16);
        slot(1'b1, 16'h3333, 16);
        slot(1'b0, 16'h4444, 16);
        check("s16_ferr_cnt", 16'(fe_cnt - s_fe), 16'd3);
        check("s16_valid_cnt", 16'(sv_cnt - s_sv), 16'd0);

        // normal stereo frames with 24-bclk slots
        do_reset();
        slot(1'b1, 16'h0000, 24);
        check("lead_lrsync", 16'(bus.lrclk_sync), 16'h0001);
        s_sv = sv_cnt;
        s_fe = fe_cnt;
        slot(1'b0, 16'h8001, 24);
        slot(1'b1, 16'h7FFE, 24);
        slot(1'b0, 16'h8001, 24);
        slot(1'b1, 16'h7FFE, 24);
        check("main_left", bus.left_sample, 16'h8001);
        check("main_right", bus.right_sample, 16'h7FFE);
        check("main_pulse_right", last_right, 16'h7FFE);
        check("main_valid_cnt", 16'(sv_cnt - s_sv), 16'd2);
        check("main_ferr_cnt", 16'(fe_cnt - s_fe), 16'd0);

        // short right slot, then a good frame
        s_sv = sv_cnt;
        s_fe = fe_cnt;
        slot(1'b0, 16'h1357, 24);
        slot(1'b1, 16'h2468, 10);
        slot(1'b0, 16'h0F0F, 24);
        check("short_ferr_cnt", 16'(fe_cnt - s_fe), 16'd1);
        check("short_valid_cnt", 16'(sv_cnt - s_sv), 16'd0);
        check("short_right_held", bus.right_sample, 16'h7FFE);
        check("short_left", bus.left_sample, 16'h0F0F);
        slot(1'b1, 16'hF0F0, 24);
        check("after_valid_cnt", 16'(sv_cnt - s_sv), 16'd1);
        check("after_right", bus.right_sample, 16'hF0F0);
        check("after_ferr_cnt", 16'(fe_cnt - s_fe), 16'd1);

        // 32-bit slots: only the top 16 bits are kept
        do_reset();
        send_slot(1'b1, 32'h0000_0000, 0, 32);
        s_sv = sv_cnt;
        s_fe = fe_cnt;
        send_slot(1'b0, 32'h1234_5678, 0, 32);
        send_slot(1'b1, 32'hCDEF_0123, 0, 32);
        check("s32_left", bus.left_sample, 16'h1234);
        check("s32_right", bus.right_sample, 16'hCDEF);
        check("s32_valid_cnt", 16'(sv_cnt - s_sv), 16'd1);
        check("s32_ferr_cnt", 16'(fe_cnt - s_fe), 16'd0);

        // reset in the middle of a right word
        do_reset();
        slot(1'b1, 16'h0000, 24);
        slot(1'b0, 16'h5555, 24);
        send_slot(1'b1, {16'h9999, 16'h0000}, 0, 9);
        bclk = 1'b0;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(6);
        reset = 1'b1;
        check("mid_rst_left", bus.left_sample, 16'h0000);
        check("mid_rst_right", bus.right_sample, 16'h0000);
        s_sv = sv_cnt;
        send_slot(1'b1, {16'h9999, 16'h0000}, 9, 24);
        slot(1'b0, 16'h3C3C, 24);
        check("mid_partial_valid", 16'(sv_cnt - s_sv), 16'd0);
        check("mid_partial_right", bus.right_sample, 16'h0000);
        check("mid_left", bus.left_sample, 16'h3C3C);
        slot(1'b1, 16'hAAAA, 24);
        check("mid_valid_cnt", 16'(sv_cnt - s_sv), 16'd1);
        check("mid_right", bus.right_sample, 16'hAAAA);
        check("mid_pulse_right", last_right, 16'hAAAA);

        // jittered clk:bclk ratio, 100 random words
        do_reset();
        jitter = 1'b1;
        slot(1'b1, 16'h0000, 24);
        s_fe = fe_cnt;
        for (int i = 0; i < 50; i++) begin
            lw = 16'($urandom);
            rw = 16'($urandom);
            s_sv = sv_cnt;
            slot(1'b0, lw, 24);
            slot(1'b1, rw, 24);
            check("rnd_valid_cnt", 16'(sv_cnt - s_sv), 16'd1);
            check("rnd_left", bus.left_sample, lw);
            check("rnd_right", bus.right_sample, rw);
        end
        check("rnd_ferr_cnt", 16'(fe_cnt - s_fe), 16'd0);
        check("valid_and_ferr", 16'(both_cnt), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
